// File: rtl/rnn_fixed_pkg.sv
// Shared fixed-point constants, sequencer state type and element-slice helper
// for the RNN datapath blocks.
package rnn_fixed_pkg;

    localparam int unsigned QN       = 6;
    localparam int unsigned QM       = 11;
    localparam int unsigned BITWIDTH = QN + QM + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } seq_state_t;

    // LSB position of element k in a packed vector of width-bit elements.
    function automatic int unsigned elem_lsb(input int unsigned k, input int unsigned width);
        return k * width;
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth delay line for a valid bit plus an element index; used to
// align issued addresses with data returned by a fixed-latency memory.
module valid_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid,
    input  logic [IDX_W-1:0] idx,
    output logic             valid_dly,
    output logic [IDX_W-1:0] idx_dly
);

    logic [DEPTH-1:0] v_pipe;
    logic [IDX_W-1:0] i_pipe [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v_pipe <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                i_pipe[i] <= '0;
            end
        end else begin
            v_pipe[0] <= valid;
            i_pipe[0] <= idx;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                v_pipe[i] <= v_pipe[i-1];
                i_pipe[i] <= i_pipe[i-1];
            end
        end
    end

    assign valid_dly = v_pipe[DEPTH-1];
    assign idx_dly   = i_pipe[DEPTH-1];

endmodule

// File: rtl/dot_prod_sequencer.sv
// Sequences one matrix-vector product: latches the input vector, walks weightRAM
// columns, feeds aligned elements to dot_prod and hands the result downstream.
module dot_prod_sequencer
    import rnn_fixed_pkg::*;
#(
    parameter int unsigned NROW          = 16,
    parameter int unsigned NCOL          = 16,
    parameter int unsigned QN            = rnn_fixed_pkg::QN,
    parameter int unsigned QM            = rnn_fixed_pkg::QM,
    parameter int unsigned BITWIDTH      = QN + QM + 1,
    parameter int unsigned ADDR_BITWIDTH = 4,
    parameter int unsigned RAM_LATENCY   = 1,
    parameter int unsigned MAC_LATENCY   = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NCOL*BITWIDTH-1:0]   inputVecIn,
    output logic                       busy,
    output logic [ADDR_BITWIDTH-1:0]   colAddress,
    output logic                       macClear,
    output logic                       macValid,
    output logic [BITWIDTH-1:0]        macElement,
    input  logic [NROW*BITWIDTH-1:0]   macResult,
    output logic                       outValid,
    input  logic                       outReady,
    output logic [NROW*BITWIDTH-1:0]   outVec
);

    localparam int unsigned DRAIN_CYCLES = RAM_LATENCY + MAC_LATENCY;
    localparam int unsigned CNT_W        = $clog2(DRAIN_CYCLES + 1);
    localparam logic [ADDR_BITWIDTH-1:0] COL_LAST   = ADDR_BITWIDTH'(NCOL - 1);
    localparam logic [CNT_W-1:0]         DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    seq_state_t state, state_nx;

    logic [NCOL*BITWIDTH-1:0] vec_q;
    logic [CNT_W-1:0]         drain_cnt;
    logic                     accept, issue_last, drain_done, handshake;
    logic                     dl_valid;
    logic [ADDR_BITWIDTH-1:0] dl_idx;
    logic [BITWIDTH-1:0]      elems [NCOL];

    always_comb begin
        state_nx   = state;
        accept     = 1'b0;
        issue_last = 1'b0;
        drain_done = 1'b0;
        handshake  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (colAddress == COL_LAST) begin
                    issue_last = 1'b1;
                    state_nx   = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    drain_done = 1'b1;
                    state_nx   = HOLD;
                end
            end
            HOLD: begin
                if (outValid && outReady) begin
                    handshake = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vec_q      <= '0;
            colAddress <= '0;
            macClear   <= 1'b0;
            drain_cnt  <= '0;
            outValid   <= 1'b0;
            outVec     <= '0;
        end else begin
            macClear <= accept;
            if (accept) begin
                vec_q      <= inputVecIn;
                colAddress <= '0;
                drain_cnt  <= '0;
            end
            // Address holds at the last column through DRAIN and HOLD.
            if (state == ISSUE && !issue_last) begin
                colAddress <= colAddress + ADDR_BITWIDTH'(1);
            end
            if (state == DRAIN) begin
                if (drain_done) begin
                    outVec   <= macResult;
                    outValid <= 1'b1;
                end else begin
                    drain_cnt <= drain_cnt + CNT_W'(1);
                end
            end
            if (handshake) begin
                outValid <= 1'b0;
            end
        end
    end

    valid_delay_line #(
        .DEPTH (RAM_LATENCY),
        .IDX_W (ADDR_BITWIDTH)
    ) u_align (
        .clock     (clock),
        .reset     (reset),
        .valid     (state == ISSUE),
        .idx       (colAddress),
        .valid_dly (dl_valid),
        .idx_dly   (dl_idx)
    );

    always_comb begin
        for (int unsigned k = 0; k < NCOL; k++) begin
            elems[k] = vec_q[elem_lsb(k, BITWIDTH) +: BITWIDTH];
        end
    end

    assign busy       = (state != IDLE);
    assign macValid   = dl_valid;
    assign macElement = dl_valid ? elems[dl_idx] : '0;

endmodule

// File: tb/tb_dot_prod_sequencer.sv
// Scoreboard bench for dot_prod_sequencer with behavioural weightRAM and
// dot_prod models; directed runs cover idle, backpressure, restart and abort.
module tb_dot_prod_sequencer;

    localparam int NROW = 16;
    localparam int NCOL = 16;
    localparam int BW   = 18;
    localparam int AW   = 4;
    localparam int VW   = NCOL * BW;
    localparam int RW   = NROW * BW;
    localparam int CW   = RW;

    logic          clock;
    logic          reset;
    logic          start;
    logic [VW-1:0] inputVecIn;
    logic          busy;
    logic [AW-1:0] colAddress;
    logic          macClear;
    logic          macValid;
    logic [BW-1:0] macElement;
    logic [RW-1:0] macResult;
    logic          outValid;
    logic          outReady;
    logic [RW-1:0] outVec;

    logic [RW-1:0] weightMemOutput;
    logic [BW-1:0] acc [NROW];
    logic [RW-1:0] held;
    logic [RW-1:0] col0;

    int   checks   = 0;
    int   failures = 0;
    int   edge_no  = 0;
    int   e0       = 0;
    bit   run_active = 1'b0;
    logic prev_ov  = 1'b0;

    logic [BW-1:0] elem_q [$];
    logic [RW-1:0] res_q  [$];

    dot_prod_sequencer #(
        .NROW          (NROW),
        .NCOL          (NCOL),
        .QN            (6),
        .QM            (11),
        .BITWIDTH      (BW),
        .ADDR_BITWIDTH (AW),
        .RAM_LATENCY   (1),
        .MAC_LATENCY   (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .inputVecIn (inputVecIn),
        .busy       (busy),
        .colAddress (colAddress),
        .macClear   (macClear),
        .macValid   (macValid),
        .macElement (macElement),
        .macResult  (macResult),
        .outValid   (outValid),
        .outReady   (outReady),
        .outVec     (outVec)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) edge_no <= edge_no + 1;

    function automatic logic [BW-1:0] wgt(input int r, input int c);
        int v;
        v = ((r * NCOL + c) * 97) % 4001 - 2000;
        return v[BW-1:0];
    endfunction

    function automatic int sx(input logic [BW-1:0] x);
        return int'($signed(x));
    endfunction

    function automatic logic [BW-1:0] mac_step(input logic [BW-1:0] a, input logic [BW-1:0] e,
                                               input logic [BW-1:0] w);
        int s;
        s = sx(a) + sx(e) * sx(w);
        return s[BW-1:0];
    endfunction

    function automatic logic [RW-1:0] exp_result(input logic [VW-1:0] v);
        logic [RW-1:0] res;
        int s;
        for (int r = 0; r < NROW; r++) begin
            s = 0;
            for (int k = 0; k < NCOL; k++) s += sx(v[k*BW +: BW]) * sx(wgt(r, k));
            res[r*BW +: BW] = s[BW-1:0];
        end
        return res;
    endfunction

    function automatic logic [VW-1:0] ramp_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < NCOL; k++) v[k*BW +: BW] = BW'(2048 * (k + 1));
        return v;
    endfunction

    function automatic logic [VW-1:0] unit_vec();
        logic [VW-1:0] v;
        v = '0;
        v[BW-1:0] = BW'(1);
        return v;
    endfunction

    function automatic logic [VW-1:0] pat_vec(input int s);
        logic [VW-1:0] v;
        int x;
        for (int k = 0; k < NCOL; k++) begin
            x = ((k + 1) * (s * 37 + 11)) % 3001 - 1500;
            v[k*BW +: BW] = x[BW-1:0];
        end
        return v;
    endfunction

    // weightRAM: one-cycle registered read of a full column
    always @(posedge clock) begin
        for (int r = 0; r < NROW; r++) weightMemOutput[r*BW +: BW] <= wgt(r, int'(colAddress));
    end

    // dot_prod: accumulate stage plus one output register
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NROW; r++) acc[r] <= '0;
            macResult <= '0;
        end else begin
            for (int r = 0; r < NROW; r++) begin
                if (macClear) acc[r] <= '0;
                else if (macValid) acc[r] <= mac_step(acc[r], macElement, weightMemOutput[r*BW +: BW]);
                macResult[r*BW +: BW] <= acc[r];
            end
        end
    end

    task automatic check(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (macValid) begin
                if (elem_q.size() == 0) begin
                    check("macValid extra", CW'(macValid), CW'(0));
                end else begin
                    if (elem_q.size() == NCOL) check("first macValid edge", CW'(edge_no - e0), CW'(1));
                    check("macElement", CW'(macElement), CW'(elem_q.pop_front()));
                end
            end else begin
                check("macElement idle", CW'(macElement), CW'(0));
            end
            if (macClear) begin
                check("macClear edge", CW'(edge_no - e0), CW'(0));
                check("macClear overlap", CW'(macValid), CW'(0));
            end
            if (run_active && busy)
                check("colAddress", CW'(colAddress),
                      CW'((edge_no - e0 < NCOL - 1) ? edge_no - e0 : NCOL - 1));
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            if (outValid && !prev_ov) check("outValid latency", CW'(edge_no - e0), CW'(NCOL + 1 + 2));
            if (outValid && outReady) begin
                if (res_q.size() == 0) check("outValid extra", CW'(outValid), CW'(0));
                else check("outVec", outVec, res_q.pop_front());
            end
        end
        prev_ov <= outValid;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic launch(input logic [VW-1:0] v);
        inputVecIn = v;
        start      = 1'b1;
        e0         = edge_no + 1;
        run_active = 1'b1;
        for (int k = 0; k < NCOL; k++) elem_q.push_back(v[k*BW +: BW]);
        res_q.push_back(exp_result(v));
        step(1);
        start = 1'b0;
    endtask

    task automatic end_checks();
        check("macValid count", CW'(elem_q.size()), CW'(0));
        check("result count", CW'(res_q.size()), CW'(0));
        run_active = 1'b0;
    endtask

    task automatic finish_run(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step(1);
            n++;
        end
        check("run completes", CW'(busy), CW'(0));
        end_checks();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset      = 1'b1;
        start      = 1'b0;
        outReady   = 1'b1;
        inputVecIn = '0;
        for (int r = 0; r < NROW; r++) col0[r*BW +: BW] = wgt(r, 0);
        #2 reset = 1'b0;
        step(2);
        check("reset ctrl", CW'({busy, macClear, macValid, outValid}), CW'(0));
        check("reset colAddress", CW'(colAddress), CW'(0));
        check("reset macElement", CW'(macElement), CW'(0));
        check("reset outVec", outVec, CW'(0));
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("idle status", CW'({busy, outValid, macValid}), CW'(0));
            check("idle colAddress", CW'(colAddress), CW'(0));
        end

        launch(ramp_vec());
        finish_run(100);

        outReady = 1'b0;
        launch(unit_vec());
        inputVecIn = pat_vec(99);
        n = 0;
        while (!outValid && n < 100) begin
            step(1);
            n++;
        end
        check("outValid rises", CW'(outValid), CW'(1));
        held = outVec;
        check("unit result column0", held, col0);
        for (int i = 0; i < 7; i++) begin
            start = (i == 3);
            step(1);
            check("hold outValid", CW'(outValid), CW'(1));
            check("hold outVec", outVec, held);
            check("hold busy", CW'(busy), CW'(1));
        end
        start    = 1'b0;
        outReady = 1'b1;
        step(1);
        check("idle after handshake", CW'({busy, outValid}), CW'(0));
        step(3);
        check("hold start ignored", CW'(busy), CW'(0));
        end_checks();

        launch(pat_vec(3));
        step(4);
        start = 1'b1;
        step(1);
        start = 1'b0;
        finish_run(100);

        launch(pat_vec(5));
        step(8);
        #2 reset = 1'b0;
        #1;
        check("abort ctrl", CW'({busy, macClear, macValid, outValid}), CW'(0));
        check("abort colAddress", CW'(colAddress), CW'(0));
        check("abort macElement", CW'(macElement), CW'(0));
        check("abort outVec", outVec, CW'(0));
        elem_q.delete();
        res_q.delete();
        run_active = 1'b0;
        step(2);
        reset = 1'b1;
        step(1);
        launch(pat_vec(7));
        finish_run(100);

        for (int s = 0; s < 20; s++) begin
            if (s % 2 == 0) launch(unit_vec());
            else launch(pat_vec(s + 20));
            finish_run(100);
        end
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dot_prod_sequencer.md
Name: dot_prod_sequencer

Overview:
- Controller that runs one matrix-vector dot product on the dot_prod datapath and the weightRAM column memory.
- On a start pulse it latches an NCOL-element input vector and steps colAddress 0..NCOL-1 into weightRAM.
- It feeds the matching input element to dot_prod, aligned to the RAM read latency, and clears the accumulators beforehand.
- It waits out the MAC pipeline, captures the NROW-wide result and offers it downstream with a valid/ready handshake.

Parameters:
- NROW, 16, rows of the weight matrix (output elements).
- NCOL, 16, columns of the weight matrix (input elements).
- QN, 6, integer bits of the fixed-point format.
- QM, 11, fractional bits of the fixed-point format.
- BITWIDTH, QN+QM+1, element width (18).
- ADDR_BITWIDTH, 4, colAddress width; must satisfy 2**ADDR_BITWIDTH >= NCOL.
- RAM_LATENCY, 1, cycles from colAddress to valid weightMemOutput (>= 1).
- MAC_LATENCY, 2, cycles from the last macValid until macResult is final (>= 1).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a new dot product; sampled only in IDLE.
- inputVecIn  in  NCOL*BITWIDTH  packed input vector; element k is [k*BITWIDTH +: BITWIDTH]; latched on the accepted start.
- busy  out  1  high in every state except IDLE.
- colAddress  out  ADDR_BITWIDTH  column address to weightRAM.
- macClear  out  1  one-cycle accumulator clear to dot_prod.
- macValid  out  1  macElement valid; dot_prod accumulates this cycle.
- macElement  out  BITWIDTH  signed input element for the current column.
- macResult  in  NROW*BITWIDTH  dot_prod accumulated output vector.
- outValid  out  1  outVec valid.
- outReady  in  1  downstream accepts outVec.
- outVec  out  NROW*BITWIDTH  captured result; holds its value until the next capture.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE.
  - busy, macClear, macValid, outValid = 0.
  - colAddress, macElement, outVec, all counters = 0.
  - The latched vector is cleared.
- States: IDLE, ISSUE, DRAIN, HOLD.
- IDLE:
  - On the edge where start=1 (edge E0): latch inputVecIn, colAddress <= 0, macClear <= 1 for exactly one cycle, go to ISSUE.
  - start=0 leaves the block in IDLE.
- ISSUE:
  - colAddress after edge E_k equals k, for k = 0..NCOL-1.
  - After issuing NCOL-1, go to DRAIN; colAddress holds NCOL-1.
- Element alignment:
  - macValid/macElement come from a RAM_LATENCY-deep delay line on (issue-valid, element index).
  - Element k is presented with macValid=1 after edge E_{k+RAM_LATENCY}.
  - macValid is high for exactly NCOL consecutive cycles and is never asserted in the same cycle as macClear.
  - macElement = 0 whenever macValid = 0.
- DRAIN:
  - Count RAM_LATENCY+MAC_LATENCY cycles after the last issue.
  - Then capture macResult into outVec, set outValid <= 1 and go to HOLD.
  - With the default parameters, outValid first rises after edge E_{NCOL+RAM_LATENCY+MAC_LATENCY} = E19.
- HOLD:
  - outValid and outVec stay stable while outReady = 0.
  - On an edge with outValid & outReady: outValid <= 0, go to IDLE.
- start outside IDLE is ignored, including during HOLD and in the handshake cycle. It is not queued.
- inputVecIn changes after the accepted start have no effect on the current run.
- No arithmetic in this block; elements pass through bit-exact as signed Q6.11. Width and saturation are dot_prod's responsibility.
- colAddress never exceeds NCOL-1 and never wraps within a run.
- Reset asserted mid-ISSUE, DRAIN or HOLD aborts the run immediately and outputs go to their reset values. The first start after release runs a full, clean sequence, with macClear issued again.

Decomposition:
- Shared package rnn_fixed_pkg:
  - QN, QM, BITWIDTH constants.
  - State encoding localparams for IDLE/ISSUE/DRAIN/HOLD.
  - Element-slice helper function.
- One natural sub-module, valid_delay_line: parameterised depth RAM_LATENCY, carries the valid bit and element index. Reused for latency alignment elsewhere in the design.

Test Plan:
- Reset then idle:
  - Hold reset low for 2 cycles, release, keep start=0 for 10 cycles.
  - busy=0, outValid=0, colAddress=0 and macValid=0 throughout.
- Address/element sequence:
  - inputVecIn element k = k+1 (Q6.11 raw 2048*(k+1)); pulse start.
  - colAddress = 0..15 on consecutive cycles.
  - macClear high only in the cycle after E0.
  - macValid high for 16 cycles starting after E1, with macElement raw 2048, 4096, …, 32768.
- Full run with real dot_prod/weightRAM:
  - Input element 0 = 1 (raw 1), other elements 0.
  - outValid rises after E19; outVec equals weightRAM column 0.
  - Check against a bench model over 500 cycles of repeated runs.
- Backpressure:
  - Hold outReady=0 for 7 cycles after outValid.
  - outVec and outValid stable; busy=1; a start pulse during HOLD is ignored.
  - Raise outReady: one handshake, then IDLE next cycle.
- Start during run:
  - Pulse start again at E5.
  - Sequence unaffected: still exactly 16 macValid cycles and a single outValid.
- Reset mid-operation:
  - Drive reset low at E8 between edges.
  - All outputs go to 0 without waiting for a clock edge.
  - After release, a new start gives a full 16-column run with a fresh macClear and the correct result.
